sync_fifo_module: RTL and testbench
===================================

SYNC_FIFO_MODULE -- requirements
Module: sync_fifo_module

Interface
REQ-001 SHALL have parameter DEPTH, default 32, storage entries; any integer >= 2, power of 2 not required.
REQ-002 SHALL have parameter WIDTH, default 8, data bits per entry.
REQ-003 SHALL have parameter SLEEP_MODE, default 0; 1 = enable input gates all handshakes.
REQ-004 SHALL have parameter LIMIT_COUNTER, default DEPTH, reach_limit threshold, 1..DEPTH.
REQ-005 SHALL have parameter AF_LEVEL, default DEPTH-2, and AE_LEVEL, default 1, almost-full and almost-empty thresholds in entries.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: enable  in  1  sleep gate; flush  in  1  synchronous clear.
REQ-008 SHALL have ports: wr_valid  in  1; wr_ready  out  1; wr_data  in  WIDTH  write channel.
REQ-009 SHALL have ports: rd_valid  out  1; rd_ready  in  1; rd_data  out  WIDTH  read channel, first-word-fall-through.
REQ-010 SHALL have ports: count  out  CW = clog2(DEPTH+1)  occupancy; full, almost_full, empty, almost_empty, reach_limit  out  1 each.
REQ-011 SHALL have ports: overflow, underflow  out  1  sticky error flags.

Function
REQ-012 Write accepted on a rising clk edge iff wr_valid & wr_ready; read accepted iff rd_valid & rd_ready.
REQ-013 wr_ready SHALL equal !full (& enable when SLEEP_MODE=1); no combinational path from rd_ready.
REQ-014 rd_valid SHALL equal !empty (& enable when SLEEP_MODE=1); no combinational path from wr_valid.
REQ-015 rd_data SHALL present the oldest entry whenever rd_valid=1, zero-cycle latency; value undefined when empty.
REQ-016 A write is visible on rd_data/rd_valid in the cycle after acceptance (write-to-read latency 1).
REQ-017 Write and read pointers SHALL advance by 1 per accepted transfer and wrap from DEPTH-1 to 0.
REQ-018 count SHALL be +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-019 Simultaneous accepted write and read at any occupancy 1..DEPTH-1 SHALL preserve order and count.
REQ-020 When full, only a read can be accepted; when empty, only a write can be accepted.
REQ-021 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); reach_limit = (count>=LIMIT_COUNTER); all registered-state-derived.
REQ-022 overflow SHALL set on the edge where wr_valid=1 and wr_ready=0 with enable active; underflow likewise for rd_ready=1 and rd_valid=0; both hold until rst or flush.
REQ-023 flush SHALL, on the edge where it is 1, zero both pointers, count, overflow and underflow; concurrent write and read in that cycle are discarded.
REQ-024 With SLEEP_MODE=1 and enable=0, state SHALL hold and error flags SHALL not set; flush and rst still act.
REQ-025 Memory contents SHALL not be reset or cleared by flush.

Reset
REQ-026 rst SHALL be sampled on the clk rising edge only and take priority over flush and all transfers.
REQ-027 After reset: count=0, empty=1, almost_empty=1, full=0, almost_full=0, reach_limit=0, wr_ready=1 (subject to enable), rd_valid=0, overflow=0, underflow=0.
REQ-028 rst asserted mid-stream SHALL drop all stored entries; a transfer in the reset cycle is not accepted.

Structure
REQ-029 Shared package fifo_pkg SHALL hold the count-width function and default threshold constants.
REQ-030 Storage SHALL be a sub-module fifo_ram: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.
REQ-031 Control (pointers, count, flags) SHALL reside in sync_fifo_module; no derived clocks or clock gating.

Verification
REQ-032 DEPTH=5: reset, write 0x11..0x55 -> full=1, count=5, wr_ready=0; 6th write sets overflow=1, count stays 5.
REQ-033 DEPTH=5 full: read 5 -> rd_data 0x11,0x22,0x33,0x44,0x55 in order, empty=1; extra read sets underflow=1.
REQ-034 count=3, simultaneous write+read for 20 cycles -> count stays 3, pointers wrap 0..4, data in order.
REQ-035 count=4 with overflow=1, assert flush with wr_valid=1 -> next cycle count=0, empty=1, overflow=0.
REQ-036 SLEEP_MODE=1, enable=0, wr_valid=1, rd_ready=1 for 10 cycles -> count, data, flags unchanged.
REQ-037 Empty, write 0xA5 -> rd_valid=1 next cycle with rd_data=0xA5; rst that cycle -> rd_valid=0, count=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers and default parameter values for the synchronous FIFO
package fifo_pkg;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_AE_LEVEL = 1;
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/sync_fifo_module_if.sv
// sync_fifo_module_if: write and read valid/ready channels of the FIFO
interface sync_fifo_module_if #(parameter int WIDTH = 8);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    modport master (output wr_valid, wr_data, rd_ready, input wr_ready, rd_valid, rd_data);
    modport slave (input wr_valid, wr_data, rd_ready, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read, never cleared
module fifo_ram import fifo_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_module.sv
// sync_fifo_module: first-word-fall-through FIFO with occupancy flags, sticky errors and sleep gating
module sync_fifo_module import fifo_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLEEP_MODE = 0,
    parameter int LIMIT_COUNTER = DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    localparam int CW = count_width(DEPTH),
    localparam int AW = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          flush,
    sync_fifo_module_if.slave bus,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          almost_full,
    output logic          empty,
    output logic          almost_empty,
    output logic          reach_limit,
    output logic          overflow,
    output logic          underflow
);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
    localparam logic [CW-1:0] LIM_C = CW'(LIMIT_COUNTER);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          en, wr_fire, rd_fire;
    assign en = (SLEEP_MODE != 0) ? enable : 1'b1;
    assign full = count == FULL_C;
    assign empty = count == '0;
    assign almost_full = count >= AF_C;
    assign almost_empty = count <= AE_C;
    assign reach_limit = count >= LIM_C;
    assign bus.wr_ready = ~full & en;
    assign bus.rd_valid = ~empty & en;
    assign wr_fire = bus.wr_valid & bus.wr_ready;
    assign rd_fire = bus.rd_valid & bus.rd_ready;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count     <= count + CW'(wr_fire) - CW'(rd_fire);
            overflow  <= overflow | (en & bus.wr_valid & ~bus.wr_ready);
            underflow <= underflow | (en & bus.rd_ready & ~bus.rd_valid);
        end
    end
    fifo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
        .clk   (clk),
        .we    (wr_fire & ~rst & ~flush),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (bus.rd_data)
    );
endmodule

// File: tb/tb_sync_fifo_module.sv
// tb_sync_fifo_module: directed scoreboard bench for the DEPTH=5 FIFO and a sleep-gated instance
module tb_sync_fifo_module;
    localparam int D = 5;
    localparam int W = 8;
    localparam int CW = $clog2(D + 1);
    logic clk = 1'b0;
    logic rst, enable, flush, enable2;
    logic [CW-1:0] count, count2;
    logic full, almost_full, empty, almost_empty, reach_limit, overflow, underflow;
    logic full2, almost_full2, empty2, almost_empty2, reach_limit2, overflow2, underflow2;
    int checks = 0;
    int failures = 0;
    int mc = 0;
    logic ov = 1'b0, un = 1'b0;
    logic [W-1:0] q [$];
    always #5 clk = ~clk;
    sync_fifo_module_if #(.WIDTH(W)) a ();
    sync_fifo_module_if #(.WIDTH(W)) s ();
    sync_fifo_module #(.DEPTH(D), .WIDTH(W), .LIMIT_COUNTER(4)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .bus(a.slave),
        .count(count), .full(full), .almost_full(almost_full), .empty(empty),
        .almost_empty(almost_empty), .reach_limit(reach_limit),
        .overflow(overflow), .underflow(underflow)
    );
    sync_fifo_module #(.DEPTH(D), .WIDTH(W), .SLEEP_MODE(1)) u1 (
        .clk(clk), .rst(rst), .enable(enable2), .flush(1'b0), .bus(s.slave),
        .count(count2), .full(full2), .almost_full(almost_full2), .empty(empty2),
        .almost_empty(almost_empty2), .reach_limit(reach_limit2),
        .overflow(overflow2), .underflow(underflow2)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_state();
        chk("count", 32'(count), 32'(mc));
        chk("full", full, mc == D);
        chk("empty", empty, mc == 0);
        chk("almost_full", almost_full, mc >= D - 2);
        chk("almost_empty", almost_empty, mc <= 1);
        chk("reach_limit", reach_limit, mc >= 4);
        chk("overflow", overflow, ov);
        chk("underflow", underflow, un);
        chk("rd_valid", a.rd_valid, mc > 0);
        chk("wr_ready", a.wr_ready, mc < D);
    endtask
    task automatic tick(input logic wv, input logic [W-1:0] wd, input logic rr, input logic fl, input logic rs);
        logic wf, rf;
        a.wr_valid = wv;
        a.wr_data = wd;
        a.rd_ready = rr;
        flush = fl;
        rst = rs;
        #1;
        if (mc > 0) chk("rd_data", 32'(a.rd_data), 32'(q[0]));
        wf = wv && mc < D;
        rf = rr && mc > 0;
        @(posedge clk);
        #1;
        if (rs || fl) begin
            q.delete();
            mc = 0;
            ov = 1'b0;
            un = 1'b0;
        end else begin
            if (rf) void'(q.pop_front());
            if (wf) q.push_back(wd);
            mc = mc + int'(wf) - int'(rf);
            ov = ov | (wv && !wf);
            un = un | (rr && !rf);
        end
        check_state();
    endtask
    initial begin
        rst = 1'b1;
        enable = 1'b1;
        enable2 = 1'b1;
        flush = 1'b0;
        a.wr_valid = 1'b0;
        a.wr_data = '0;
        a.rd_ready = 1'b0;
        s.wr_valid = 1'b0;
        s.wr_data = '0;
        s.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_state();
        for (int i = 1; i <= 5; i++) tick(1'b1, W'(i * 8'h11), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, W'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1, W'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
        tick(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hD3, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        a.rd_ready = 1'b0;
        s.wr_valid = 1'b1;
        s.wr_data = 8'h3C;
        @(posedge clk);
        #1;
        s.wr_data = 8'h4D;
        @(posedge clk);
        #1;
        s.wr_valid = 1'b0;
        #1;
        chk("sleep_count_pre", 32'(count2), 32'd2);
        enable2 = 1'b0;
        s.wr_valid = 1'b1;
        s.wr_data = 8'h99;
        s.rd_ready = 1'b1;
        #1;
        chk("sleep_wr_ready", s.wr_ready, 1'b0);
        chk("sleep_rd_valid", s.rd_valid, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("sleep_count", 32'(count2), 32'd2);
        chk("sleep_overflow", overflow2, 1'b0);
        chk("sleep_underflow", underflow2, 1'b0);
        s.wr_valid = 1'b0;
        s.rd_ready = 1'b0;
        enable2 = 1'b1;
        #1;
        chk("wake_rd_valid", s.rd_valid, 1'b1);
        chk("wake_rd_data", 32'(s.rd_data), 32'h3C);
        s.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("wake_rd_data2", 32'(s.rd_data), 32'h4D);
        chk("wake_count", 32'(count2), 32'd1);
        s.rd_ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
